mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WDTH, default 4, SHALL set the word address width.
REQ-002 Parameter DATA_WDTH, default 32, SHALL set the data word width.
REQ-003 Parameter RESP_WDTH, default 1, SHALL set the response width; 0 = OKAY, 1 (zero-extended) = ERR.
REQ-004 Parameter MEM_DEPTH, default 16, SHALL set the number of implemented words; MEM_DEPTH <= 2^ADDR_WDTH.
REQ-005 Parameter STALL_CYCLES, default 2, SHALL set the extra response wait states; it is used only under MEM_RESPONDER_STALL_EN.
REQ-006 Ports SHALL be as follows:
- clk, in, 1: the single clock; all logic is rising-edge.
- rst_n, in, 1: synchronous, active-low reset.
- ar_valid, in, 1; ar_address, in, ADDR_WDTH; ar_ready, out, 1: read address channel.
- r_valid, out, 1; r_data, out, DATA_WDTH; r_resp, out, RESP_WDTH; r_ready, in, 1: read data channel.
- aw_valid, in, 1; aw_address, in, ADDR_WDTH; aw_ready, out, 1: write address channel.
- w_valid, in, 1; w_data, in, DATA_WDTH; w_ready, out, 1: write data channel.
- b_valid, out, 1; b_resp, out, RESP_WDTH; b_ready, in, 1: write response channel.
- bd_we, in, 1; bd_addr, in, ADDR_WDTH; bd_wdata, in, DATA_WDTH; bd_rdata, out, DATA_WDTH: bench backdoor port.

Function
REQ-007 Storage SHALL be MEM_DEPTH words of DATA_WDTH bits; an address >= MEM_DEPTH is out of range.
REQ-008 A handshake on any channel SHALL occur on the rising edge where its valid and ready are both 1.
REQ-009 The read FSM SHALL have states R_IDLE, R_STALL and R_RESP, and SHALL drive ar_ready=1 only in R_IDLE.
REQ-010 On the AR handshake the block SHALL capture mem[ar_address] and go to R_RESP; under the stall macro with STALL_CYCLES>0 it SHALL go to R_STALL instead.
REQ-011 For an out-of-range read, r_data SHALL be 0 and r_resp SHALL be ERR; otherwise r_resp SHALL be OKAY.
REQ-012 In R_RESP, r_valid=1 and r_data/r_resp SHALL stay stable until the R handshake, after which the FSM SHALL return to R_IDLE.
- Minimum read turnaround is 2 cycles.
REQ-013 The write FSM SHALL have states W_IDLE, W_STALL and W_RESP.
REQ-014 In W_IDLE, AW and W SHALL be accepted independently, in either order or in the same cycle; each ready SHALL drop after its own handshake.
REQ-015 On the edge where the later of AW/W is accepted (or both together), an in-range write SHALL commit to memory and the FSM SHALL go to W_RESP.
- Under the stall macro with STALL_CYCLES>0 the FSM SHALL go to W_STALL instead.
REQ-016 An out-of-range write SHALL be discarded with b_resp=ERR; otherwise b_resp SHALL be OKAY.
REQ-017 In W_RESP, b_valid=1 and SHALL stay stable until the B handshake; aw_ready and w_ready SHALL be 0 from acceptance until that handshake completes.
REQ-018 Read and write FSMs SHALL run concurrently.
- A read captured on the same edge as a write commit to the same address returns the old data.
REQ-019 bd_rdata SHALL equal mem[bd_addr] combinationally, or 0 when bd_addr is out of range.
- bd_we SHALL write bd_wdata on the clock edge; out-of-range bd writes are ignored.
REQ-020 If bd_we and an AXI commit hit the same address on the same edge, the backdoor write SHALL win.
REQ-021 The valid outputs SHALL never depend combinationally on r_ready or b_ready.

Reset
REQ-022 While rst_n=0 at a clock edge, both FSMs SHALL return to idle and the captured AW/W flags and stall counters SHALL clear.
REQ-023 While rst_n=0, all ready and valid outputs SHALL be 0, and r_data, r_resp and b_resp SHALL be 0.
REQ-024 Reset mid-transaction SHALL abort the transaction; a pending write not yet committed SHALL be dropped.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 With MEM_RESPONDER_STALL_EN defined, R_STALL and W_STALL SHALL each hold exactly STALL_CYCLES cycles before R_RESP/W_RESP.
- valid SHALL be 0 and ar_ready/aw_ready/w_ready SHALL be 0 during the stall.
REQ-027 Without MEM_RESPONDER_STALL_EN, the stall states and counters SHALL NOT be synthesized.
- Responses SHALL assert in the cycle after acceptance.

Verification
REQ-028 Backdoor mem[3]=0xDEADBEEF; read addr 3 with r_ready=1 -> r_valid 1 cycle after AR, r_data=0xDEADBEEF, r_resp=0.
REQ-029 W handshake (data 0x12345678) 2 cycles before AW (addr 5) -> single B with b_resp=0 one cycle after AW; bd_rdata@5=0x12345678.
REQ-030 MEM_DEPTH=12: write addr 14, then read addr 14 -> b_resp=1, r_resp=1, r_data=0; bd_rdata at addresses 0-11 unchanged.
REQ-031 Hold r_ready=0 for 5 cycles -> r_valid/r_data stable, ar_ready=0 throughout; handshake on cycle 6.
REQ-032 Same-edge AR and AW+W to addr 2 (old 0xA, new 0xB) -> r_data=0xA, then bd_rdata@2=0xB.
REQ-033 Macro on, STALL_CYCLES=2: r_valid rises 3 cycles after AR; rst_n=0 during stall -> no r_valid, ar_ready=1 after release.

Source files
------------

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Small AXI-lite-style memory target. A read FSM and a write FSM run side by
//   side over a MEM_DEPTH x DATA_WDTH word array. A bench backdoor port gives
//   direct combinational read access and clocked write access to the array.
//   Out-of-range accesses return ERR. Read data is zero and writes are
//   discarded.
//
// Configuration macro:
//   MEM_RESPONDER_STALL_EN : when defined, each response is delayed by
//                            STALL_CYCLES wait states (R_STALL / W_STALL).
//                            When undefined, the stall logic is not built.
//
// Ports:
//   clk          in   1          rising-edge clock
//   rst_n        in   1          synchronous active-low reset
//   ar_valid     in   1          read address valid
//   ar_address   in   ADDR_WDTH  read word address
//   ar_ready     out  1          read address ready (R_IDLE only)
//   r_valid      out  1          read data valid
//   r_data       out  DATA_WDTH  read data
//   r_resp       out  RESP_WDTH  read response (0 OKAY, 1 ERR)
//   r_ready      in   1          read data ready
//   aw_valid     in   1          write address valid
//   aw_address   in   ADDR_WDTH  write word address
//   aw_ready     out  1          write address ready
//   w_valid      in   1          write data valid
//   w_data       in   DATA_WDTH  write data
//   w_ready      out  1          write data ready
//   b_valid      out  1          write response valid
//   b_resp       out  RESP_WDTH  write response (0 OKAY, 1 ERR)
//   b_ready      in   1          write response ready
//   bd_we        in   1          backdoor write enable
//   bd_addr      in   ADDR_WDTH  backdoor address
//   bd_wdata     in   DATA_WDTH  backdoor write data
//   bd_rdata     out  DATA_WDTH  backdoor read data (0 when out of range)
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WDTH    = 4,
    parameter int DATA_WDTH    = 32,
    parameter int RESP_WDTH    = 1,
    parameter int MEM_DEPTH    = 16,
    parameter int STALL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // read address channel
    input  logic                 ar_valid,
    input  logic [ADDR_WDTH-1:0] ar_address,
    output logic                 ar_ready,
    // read data channel
    output logic                 r_valid,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 r_ready,
    // write address channel
    input  logic                 aw_valid,
    input  logic [ADDR_WDTH-1:0] aw_address,
    output logic                 aw_ready,
    // write data channel
    input  logic                 w_valid,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 w_ready,
    // write response channel
    output logic                 b_valid,
    output logic [RESP_WDTH-1:0] b_resp,
    input  logic                 b_ready,
    // backdoor
    input  logic                 bd_we,
    input  logic [ADDR_WDTH-1:0] bd_addr,
    input  logic [DATA_WDTH-1:0] bd_wdata,
    output logic [DATA_WDTH-1:0] bd_rdata
);

    localparam logic [RESP_WDTH-1:0] RESP_OKAY = '0;
    localparam logic [RESP_WDTH-1:0] RESP_ERR  = RESP_WDTH'(1);
    // One extra bit so MEM_DEPTH == 2**ADDR_WDTH is representable.
    localparam logic [ADDR_WDTH:0]   DEPTH_LIM = (ADDR_WDTH+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_STALL, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_STALL, W_RESP} w_state_t;

    function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DATA_WDTH-1:0] mem [MEM_DEPTH];

    // Write-side commit strobe and its address/data, from the write FSM below.
    logic                 commit;
    logic [ADDR_WDTH-1:0] commit_addr;
    logic [DATA_WDTH-1:0] commit_data;

    // NOTE: the array has no reset branch; its contents must survive rst_n,
    // and a reset would also stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (commit && in_range(commit_addr)) begin
            mem[commit_addr] <= commit_data;
        end
        // Issued after the AXI write so the backdoor wins a same-address edge.
        if (bd_we && in_range(bd_addr)) begin
            mem[bd_addr] <= bd_wdata;
        end
    end

    assign bd_rdata = in_range(bd_addr) ? mem[bd_addr] : '0;

    // -----------------------------------------------------------------------
    // Read FSM
    // -----------------------------------------------------------------------
    r_state_t             r_state;
    r_state_t             r_next;
    logic                 ar_fire;
    logic                 r_fire;
    logic [DATA_WDTH-1:0] r_data_q;
    logic [RESP_WDTH-1:0] r_resp_q;

    assign ar_fire = ar_valid && ar_ready;
    assign r_fire  = r_valid && r_ready;

`ifdef MEM_RESPONDER_STALL_EN
    localparam int              CNT_W    = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CYCLES - 1);
    localparam logic            STALL_ON = (STALL_CYCLES > 0);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;

    // Counts completed stall cycles. It is zero on entry to the stall state.
    always_ff @(posedge clk) begin
        if (!rst_n || r_state != R_STALL) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // NOTE: combinational blocks assign a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: begin
                if (ar_fire) begin
`ifdef MEM_RESPONDER_STALL_EN
                    r_next = STALL_ON ? R_STALL : R_RESP;
`else
                    r_next = R_RESP;
`endif
                end
            end
            R_STALL: begin
`ifdef MEM_RESPONDER_STALL_EN
                if (r_cnt == CNT_LAST) begin
                    r_next = R_RESP;
                end
`else
                r_next = R_RESP;
`endif
            end
            R_RESP: begin
                if (r_fire) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        if (rst_n) begin
            ar_ready = (r_state == R_IDLE);
            r_valid  = (r_state == R_RESP);
        end
    end

    // Read data is captured at acceptance, so a same-edge write commit to the
    // same word is not visible to this read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            if (in_range(ar_address)) begin
                r_data_q <= mem[ar_address];
                r_resp_q <= RESP_OKAY;
            end else begin
                r_data_q <= '0;
                r_resp_q <= RESP_ERR;
            end
        end
    end

    assign r_data = rst_n ? r_data_q : '0;
    assign r_resp = rst_n ? r_resp_q : '0;

    // -----------------------------------------------------------------------
    // Write FSM
    // -----------------------------------------------------------------------
    w_state_t             w_state;
    w_state_t             w_next;
    logic                 aw_fire;
    logic                 w_fire;
    logic                 b_fire;
    logic                 aw_got;
    logic                 w_got;
    logic [ADDR_WDTH-1:0] aw_addr_q;
    logic [DATA_WDTH-1:0] w_data_q;
    logic [RESP_WDTH-1:0] b_resp_q;

    assign aw_fire = aw_valid && aw_ready;
    assign w_fire  = w_valid && w_ready;
    assign b_fire  = b_valid && b_ready;

    // Commit on the edge that supplies the second half (or both halves).
    assign commit      = (w_state == W_IDLE) && (aw_got || aw_fire) && (w_got || w_fire);
    assign commit_addr = aw_fire ? aw_address : aw_addr_q;
    assign commit_data = w_fire ? w_data : w_data_q;

`ifdef MEM_RESPONDER_STALL_EN
    always_ff @(posedge clk) begin
        if (!rst_n || w_state != W_STALL) begin
            w_cnt <= '0;
        end else begin
            w_cnt <= w_cnt + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: begin
                if (commit) begin
`ifdef MEM_RESPONDER_STALL_EN
                    w_next = STALL_ON ? W_STALL : W_RESP;
`else
                    w_next = W_RESP;
`endif
                end
            end
            W_STALL: begin
`ifdef MEM_RESPONDER_STALL_EN
                if (w_cnt == CNT_LAST) begin
                    w_next = W_RESP;
                end
`else
                w_next = W_RESP;
`endif
            end
            W_RESP: begin
                if (b_fire) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        if (rst_n) begin
            aw_ready = (w_state == W_IDLE) && !aw_got;
            w_ready  = (w_state == W_IDLE) && !w_got;
            b_valid  = (w_state == W_RESP);
        end
    end

    // Half-accepted flags. Reset drops a write whose other half never came.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else if (commit) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_got <= 1'b1;
            end
            if (w_fire) begin
                w_got <= 1'b1;
            end
        end
    end

    // Payload holding registers are only read while their flag is set.
    always_ff @(posedge clk) begin
        if (aw_fire) begin
            aw_addr_q <= aw_address;
        end
        if (w_fire) begin
            w_data_q <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_resp_q <= RESP_OKAY;
        end else if (commit) begin
            b_resp_q <= in_range(commit_addr) ? RESP_OKAY : RESP_ERR;
        end
    end

    assign b_resp = rst_n ? b_resp_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Randomized scoreboard bench for mem_responder (MEM_DEPTH=12, so addresses
//   12..15 are out of range). The driver pushes expected responses into
//   queues. Negedge monitors pop and compare on each R/B handshake.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 12;
    localparam int STALL = 2;
`ifdef MEM_RESPONDER_STALL_EN
    localparam int LAT = STALL + 1;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ar_valid, ar_ready, r_valid, r_ready;
    logic [AW-1:0] ar_address;
    logic [DW-1:0] r_data;
    logic [0:0]    r_resp;
    logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [AW-1:0] aw_address;
    logic [DW-1:0] w_data;
    logic [0:0]    b_resp;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_wdata, bd_rdata;

    mem_responder #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(1),
        .MEM_DEPTH(DEPTH), .STALL_CYCLES(STALL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(ar_valid), .ar_address(ar_address), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
        .aw_valid(aw_valid), .aw_address(aw_address), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [0:0]    resp;
    } r_exp_t;

    r_exp_t     r_exp_q[$];
    logic [0:0] b_exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: word array with an out-of-range rule.
    function automatic r_exp_t model_read(input int a);
        r_exp_t e;
        if (a < DEPTH) begin
            e.data = ref_mem[a];
            e.resp = 1'b0;
        end else begin
            e.data = '0;
            e.resp = 1'b1;
        end
        return e;
    endfunction

    // Monitors: compare at negedge when a handshake is about to happen.
    always @(negedge clk) begin
        if (rst_n && r_valid && r_ready) begin
            if (r_exp_q.size() == 0) begin
                check("r_unexpected", 1, 0);
            end else begin
                r_exp_t e;
                e = r_exp_q.pop_front();
                check("r_data", r_data, e.data);
                check("r_resp", r_resp, e.resp);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_valid && b_ready) begin
            if (b_exp_q.size() == 0) begin
                check("b_unexpected", 1, 0);
            end else begin
                logic [0:0] e;
                e = b_exp_q.pop_front();
                check("b_resp", b_resp, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = AW'(a); bd_wdata = d;
        tick();
        bd_we = 1'b0;
        if (a < DEPTH) ref_mem[a] = d;
    endtask

    task automatic bd_check(input int a);
        r_exp_t e;
        e = model_read(a);
        bd_addr = AW'(a);
        #1;
        check("bd_rdata", bd_rdata, e.data);
    endtask

    task automatic do_read(input int a, input int hold);
        r_exp_t e;
        int     cyc;
        e = model_read(a);
        r_exp_q.push_back(e);
        ar_valid = 1'b1; ar_address = AW'(a); r_ready = (hold == 0);
        cyc = 0;
        while (!ar_ready && cyc < 20) begin tick(); cyc++; end
        tick();
        ar_valid = 1'b0;
        cyc = 1;
        while (!r_valid && cyc < 20) begin
            check("ar_ready_busy", ar_ready, 0);
            tick(); cyc++;
        end
        check("r_latency", cyc, LAT);
        for (int k = 0; k < hold; k++) begin
            check("r_hold_valid", r_valid, 1);
            check("r_hold_data", r_data, e.data);
            check("r_hold_ar_ready", ar_ready, 0);
            tick();
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap in cycles.
    task automatic do_write(input int a, input logic [DW-1:0] d, input int order,
                            input int gap, input int hold);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int t = 0;
        int cyc;
        b_exp_q.push_back((a < DEPTH) ? 1'b0 : 1'b1);
        if (a < DEPTH) ref_mem[a] = d;
        aw_address = AW'(a); w_data = d; b_ready = (hold == 0);
        while (!(aw_done && w_done) && t < 40) begin
            aw_valid = !aw_done && (order != 2 || t >= gap);
            w_valid  = !w_done  && (order != 1 || t >= gap);
            if (w_done)  check("w_ready_dropped", w_ready, 0);
            if (aw_done) check("aw_ready_dropped", aw_ready, 0);
            aw_hs = aw_valid && aw_ready;
            w_hs  = w_valid && w_ready;
            tick(); t++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        cyc = 1;
        while (!b_valid && cyc < 20) begin tick(); cyc++; end
        check("b_latency", cyc, LAT);
        for (int k = 0; k < hold; k++) begin
            check("b_hold_valid", b_valid, 1);
            check("b_hold_readies", {aw_ready, w_ready}, 2'b00);
            tick();
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        bd_check(a);
    endtask

    task automatic drain(input string name);
        int n = 0;
        r_ready = 1'b1; b_ready = 1'b1;
        while ((r_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 20) begin tick(); n++; end
        r_ready = 1'b0; b_ready = 1'b0;
        check(name, r_exp_q.size() + b_exp_q.size(), 0);
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {ar_ready, aw_ready, w_ready, r_valid, b_valid, r_data, r_resp, b_resp}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ar_valid = 0; ar_address = '0; r_ready = 0;
        aw_valid = 0; aw_address = '0; w_valid = 0; w_data = '0; b_ready = 0;
        bd_we = 0; bd_addr = '0; bd_wdata = '0;
        repeat (3) tick();
        check_reset_outs("reset_outputs");
        // Memory is loaded through the backdoor while reset is still held.
        for (int i = 0; i < 16; i++) bd_write(i, $urandom);
        rst_n = 1'b1;
        tick();
        check("idle_readies", {ar_ready, aw_ready, w_ready, r_valid, b_valid}, 5'b11100);

        // Basic read.
        bd_write(3, 32'hDEADBEEF);
        do_read(3, 0);
        // W two cycles before AW.
        do_write(5, 32'h12345678, 2, 2, 0);
        // Out-of-range write then read; in-range words untouched.
        do_write(14, 32'hCAFEF00D, 0, 0, 1);
        do_read(14, 0);
        for (int i = 0; i < DEPTH; i++) bd_check(i);
        // Backpressured read.
        do_read(7, 5);

        // Same-edge read and write to one word: read returns old data.
        bd_write(2, 32'hA);
        r_exp_q.push_back(model_read(2));
        b_exp_q.push_back(1'b0);
        ref_mem[2] = 32'hB;
        ar_valid = 1; ar_address = 2; aw_valid = 1; aw_address = 2;
        w_valid = 1; w_data = 32'hB;
        tick();
        ar_valid = 0; aw_valid = 0; w_valid = 0;
        drain("same_edge_drain");
        bd_check(2);

        // Backdoor write wins over an AXI commit on the same edge.
        b_exp_q.push_back(1'b0);
        ref_mem[9] = 32'h5555_AAAA;
        aw_valid = 1; aw_address = 9; w_valid = 1; w_data = 32'h1111_2222;
        bd_we = 1; bd_addr = 9; bd_wdata = 32'h5555_AAAA;
        tick();
        aw_valid = 0; w_valid = 0; bd_we = 0;
        drain("collide_drain");
        bd_check(9);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            int sel;
            int a;
            sel = $urandom_range(0, 2);
            a   = $urandom_range(0, 15);
            case (sel)
                0: do_read(a, $urandom_range(0, 3));
                1: do_write(a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                            $urandom_range(0, 3));
                default: begin
                    bd_write(a, $urandom);
                    bd_check(a);
                end
            endcase
        end

        // Reset in the middle of a read aborts it.
        r_ready = 0; ar_valid = 1; ar_address = 1;
        tick();
        ar_valid = 0;
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outs("reset_mid_read_comb");
        tick();
        check_reset_outs("reset_mid_read_edge");
        rst_n = 1'b1;
        #1;
        check("after_reset_ar_ready", ar_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("after_reset_no_r_valid", r_valid, 0);
        end

        // Reset with only AW accepted drops the write.
        aw_valid = 1; aw_address = 7;
        tick();
        aw_valid = 0;
        check("aw_ready_after_aw", aw_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("dropped_write_readies", {aw_ready, w_ready, b_valid}, 3'b110);
        bd_check(7);
        tick();
        check("dropped_write_no_b", b_valid, 0);

        check("queues_empty", r_exp_q.size() + b_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
